// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with a pattern history table of saturating counters,
// indexed bimodally or gshare-style by a non-speculative global history register.
module branch_target_predictor #(
    parameter int PC_W      = 64,
    parameter int N_ENTRIES = 16,
    parameter int TAG_BITS  = 8,
    parameter int CNT_BITS  = 2,
    parameter int GHR_BITS  = 0,
    localparam int IDX_W    = $clog2(N_ENTRIES),
    localparam int HIST_W   = (GHR_BITS > 0) ? GHR_BITS : 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [PC_W-1:0]   IF_PC,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_mispredict,
    input  logic              clear_all,
    output logic [31:0]       mispredict_cnt
);

    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] PHT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

    logic [N_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q [N_ENTRIES];
    logic [TAG_BITS-1:0]  tag_d [N_ENTRIES];
    logic [PC_W-1:0]      tgt_q [N_ENTRIES];
    logic [PC_W-1:0]      tgt_d [N_ENTRIES];
    logic [CNT_BITS-1:0]  pht_q [N_ENTRIES];
    logic [CNT_BITS-1:0]  pht_d [N_ENTRIES];
    logic [HIST_W-1:0]    ghr_q, ghr_d;
    logic [31:0]          mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX_W-1:0]     lk_idx, lk_hist, lk_pht_idx;
    logic [IDX_W-1:0]     up_idx, up_hist, up_pht_idx;
    logic [TAG_BITS-1:0]  lk_tag, up_tag;
    logic [CNT_BITS-1:0]  up_ctr;
    logic                 unused_bits;

    assign lk_idx = IF_PC[IDX_W+1:2];
    assign lk_tag = IF_PC[IDX_W+TAG_BITS+1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[IDX_W+TAG_BITS+1:IDX_W+2];

    // Bimodal mode keeps the GHR flop pinned at zero, so pred_hist reads 0 for free.
    if (GHR_BITS > 0) begin : g_gshare
        assign lk_hist = IDX_W'(ghr_q);
        assign up_hist = IDX_W'(upd_hist);
    end else begin : g_bimodal
        assign lk_hist = '0;
        assign up_hist = '0;
    end

    assign lk_pht_idx  = lk_idx ^ lk_hist;
    assign up_pht_idx  = up_idx ^ up_hist;
    assign up_ctr      = pht_q[up_pht_idx];
    assign unused_bits = ^{IF_PC, upd_pc, upd_hist};

    assign pred_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken     = pred_hit && pht_q[lk_pht_idx][CNT_BITS-1];
    assign pred_target    = pred_hit ? tgt_q[lk_idx] : '0;
    assign pred_hist      = ghr_q;
    assign mispredict_cnt = mispredict_cnt_q;

    always_comb begin
        valid_d          = valid_q;
        tag_d            = tag_q;
        tgt_d            = tgt_q;
        pht_d            = pht_q;
        ghr_d            = ghr_q;
        mispredict_cnt_d = mispredict_cnt_q;

        if (upd_valid) begin
            if (upd_taken && (up_ctr != CNT_MAX)) begin
                pht_d[up_pht_idx] = up_ctr + CNT_BITS'(1);
            end else if (!upd_taken && (up_ctr != '0)) begin
                pht_d[up_pht_idx] = up_ctr - CNT_BITS'(1);
            end
            if (upd_taken && !clear_all) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = upd_target;
            end
            if (GHR_BITS > 0) begin
                ghr_d = HIST_W'({ghr_q, upd_taken});
            end
            if (upd_mispredict && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_d = mispredict_cnt_q + 32'd1;
            end
        end

        // A flush beats a same-cycle BTB write and history shift.
        if (clear_all) begin
            valid_d = '0;
            ghr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q          <= '0;
            ghr_q            <= '0;
            mispredict_cnt_q <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                pht_q[i] <= PHT_INIT;
            end
        end else begin
            valid_q          <= valid_d;
            tag_q            <= tag_d;
            tgt_q            <= tgt_d;
            pht_q            <= pht_d;
            ghr_q            <= ghr_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: a bimodal and a 2-bit gshare instance share stimulus and
// are checked every cycle against a table-level model, plus hand-computed directed checks.
module tb_branch_target_predictor;

    logic        clk;
    logic        arst_n;
    logic [63:0] IF_PC;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic [0:0]  upd_hist0;
    logic [1:0]  upd_hist2;
    logic        upd_mispredict;
    logic        clear_all;
    logic        check_en;

    logic        hit0, taken0, hit2, taken2;
    logic [63:0] target0, target2;
    logic [0:0]  hist0;
    logic [1:0]  hist2;
    logic [31:0] cnt0, cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: BTB contents shared by both instances, separate PHTs, 2-bit history.
    bit          m_valid [16];
    logic [7:0]  m_tag   [16];
    logic [63:0] m_tgt   [16];
    int          m_pht0  [16];
    int          m_pht2  [16];
    int          m_ghr2;
    logic [31:0] m_cnt;

    branch_target_predictor #(.GHR_BITS(0)) dut0 (
        .clk(clk), .arst_n(arst_n), .IF_PC(IF_PC),
        .pred_hit(hit0), .pred_taken(taken0), .pred_target(target0), .pred_hist(hist0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_hist(upd_hist0), .upd_mispredict(upd_mispredict),
        .clear_all(clear_all), .mispredict_cnt(cnt0)
    );

    branch_target_predictor #(.GHR_BITS(2)) dut2 (
        .clk(clk), .arst_n(arst_n), .IF_PC(IF_PC),
        .pred_hit(hit2), .pred_taken(taken2), .pred_target(target2), .pred_hist(hist2),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_hist(upd_hist2), .upd_mispredict(upd_mispredict),
        .clear_all(clear_all), .mispredict_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idxOf(input logic [63:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic [7:0] tagOf(input logic [63:0] pc);
        return 8'((pc / 64) % 256);
    endfunction

    function automatic int satStep(input int ctr, input logic up);
        if (up) return (ctr < 3) ? ctr + 1 : 3;
        return (ctr > 0) ? ctr - 1 : 0;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_pht0[i]  = 1;
            m_pht2[i]  = 1;
        end
        m_ghr2 = 0;
        m_cnt  = '0;
    endtask

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            modelReset();
        end else begin
            if (upd_valid) begin
                int i;
                i = idxOf(upd_pc);
                m_pht0[i]                = satStep(m_pht0[i], upd_taken);
                m_pht2[i ^ int'(upd_hist2)] = satStep(m_pht2[i ^ int'(upd_hist2)], upd_taken);
                if (upd_mispredict && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (upd_taken && !clear_all) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tagOf(upd_pc);
                    m_tgt[i]   = upd_target;
                end
                m_ghr2 = (m_ghr2 * 2 + int'(upd_taken)) % 4;
            end
            if (clear_all) begin
                for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
                m_ghr2 = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Every falling edge: compare both instances against the model's view of the tables.
    always @(negedge clk) begin
        if (check_en) begin
            int          i;
            bit          e_hit;
            logic [63:0] e_tgt;
            i     = idxOf(IF_PC);
            e_hit = m_valid[i] && (m_tag[i] == tagOf(IF_PC));
            e_tgt = e_hit ? m_tgt[i] : 64'd0;
            checkOutput("cyc_hit0",    64'(hit0),    64'(e_hit));
            checkOutput("cyc_taken0",  64'(taken0),  64'(e_hit && m_pht0[i] >= 2));
            checkOutput("cyc_target0", target0,      e_tgt);
            checkOutput("cyc_hist0",   64'(hist0),   64'd0);
            checkOutput("cyc_cnt0",    64'(cnt0),    64'(m_cnt));
            checkOutput("cyc_hit2",    64'(hit2),    64'(e_hit));
            checkOutput("cyc_taken2",  64'(taken2),  64'(e_hit && m_pht2[i ^ m_ghr2] >= 2));
            checkOutput("cyc_target2", target2,      e_tgt);
            checkOutput("cyc_hist2",   64'(hist2),   64'(m_ghr2));
            checkOutput("cyc_cnt2",    64'(cnt2),    64'(m_cnt));
        end
    end

    task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic tk,
                                 input logic [63:0] tgt, input logic [1:0] h2,
                                 input logic mis, input logic clr);
        @(posedge clk);
        #2;
        upd_valid      = v;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_hist2      = h2;
        upd_mispredict = mis;
        clear_all      = clr;
        @(posedge clk);
        #2;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        clear_all      = 1'b0;
    endtask

    task automatic setPc(input logic [63:0] pc);
        IF_PC = pc;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        arst_n = 1'b1; IF_PC = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_hist0 = '0; upd_hist2 = '0; upd_mispredict = 1'b0;
        clear_all = 1'b0; check_en = 1'b0;
        modelReset();
        #1 arst_n = 1'b0;
        #1 check_en = 1'b1;

        // Reset state
        setPc(64'h40);
        checkOutput("rst_hit",    64'(hit0),    64'd0);
        checkOutput("rst_taken",  64'(taken0),  64'd0);
        checkOutput("rst_target", target0,      64'd0);
        checkOutput("rst_cnt",    64'(cnt0),    64'd0);
        repeat (2) @(posedge clk);
        #2 arst_n = 1'b1;

        // Training and counter walk at idx 0
        applyStimulus(1, 64'h40, 1, 64'h100, 2'd0, 0, 0);
        setPc(64'h40);
        checkOutput("train_hit0",    64'(hit0),   64'd1);
        checkOutput("train_taken0",  64'(taken0), 64'd1);
        checkOutput("train_target0", target0,     64'h100);
        checkOutput("train_taken2",  64'(taken2), 64'd0);
        checkOutput("train_hist2",   64'(hist2),  64'd1);
        applyStimulus(1, 64'h40, 1, 64'h100, 2'd0, 0, 0);
        setPc(64'h40);
        checkOutput("ctr11_taken0", 64'(taken0), 64'd1);
        applyStimulus(1, 64'h40, 0, 64'h0, 2'd0, 0, 0);
        applyStimulus(1, 64'h40, 0, 64'h0, 2'd0, 0, 0);
        setPc(64'h40);
        checkOutput("ctr01_hit0",   64'(hit0),   64'd1);
        checkOutput("ctr01_taken0", 64'(taken0), 64'd0);

        // Tag alias at idx 0
        applyStimulus(1, 64'h40, 1, 64'h100, 2'd0, 0, 0);
        applyStimulus(1, 64'h80, 1, 64'h200, 2'd0, 0, 0);
        setPc(64'h40);
        checkOutput("alias_hit40",    64'(hit0), 64'd0);
        checkOutput("alias_target40", target0,   64'd0);
        setPc(64'h80);
        checkOutput("alias_hit80",     64'(hit0), 64'd1);
        checkOutput("alias_target80",  target0,   64'h200);
        checkOutput("alias_target80g", target2,   64'h200);

        // Saturation of the PHT and the mispredict counter
        applyStimulus(0, 64'h44, 0, 64'h0, 2'd0, 1, 0);
        checkOutput("idle_mis_cnt0", 64'(cnt0), 64'd0);
        repeat (5) applyStimulus(1, 64'h80, 1, 64'h200, 2'd0, 0, 0);
        setPc(64'h80);
        checkOutput("sat_taken0", 64'(taken0), 64'd1);
        force dut0.mispredict_cnt_q = 32'hFFFF_FFFE;
        force dut2.mispredict_cnt_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        #1;
        release dut0.mispredict_cnt_q;
        release dut2.mispredict_cnt_q;
        repeat (3) applyStimulus(1, 64'h44, 0, 64'h0, 2'd0, 1, 0);
        checkOutput("sat_cnt0", 64'(cnt0), 64'hFFFF_FFFF);
        checkOutput("sat_cnt2", 64'(cnt2), 64'hFFFF_FFFF);

        // Gshare indexing: history 11 steers idx 0 lookups to PHT[3]
        applyStimulus(1, 64'h48, 1, 64'h300, 2'd0, 0, 0);
        applyStimulus(1, 64'h48, 1, 64'h300, 2'd0, 0, 0);
        setPc(64'h80);
        checkOutput("gs_hit2",    64'(hit2),   64'd1);
        checkOutput("gs_hist2",   64'(hist2),  64'd3);
        checkOutput("gs_taken2",  64'(taken2), 64'd0);
        checkOutput("gs_taken0",  64'(taken0), 64'd1);
        applyStimulus(1, 64'h80, 1, 64'h200, 2'd3, 0, 0);
        setPc(64'h80);
        checkOutput("gs_upd_taken2", 64'(taken2), 64'd1);
        checkOutput("gs_upd_hist2",  64'(hist2),  64'd3);

        // Flush together with a taken update
        applyStimulus(1, 64'h4C, 1, 64'h400, 2'd0, 0, 1);
        setPc(64'h80);
        checkOutput("clr_hit0",  64'(hit0),  64'd0);
        checkOutput("clr_hit2",  64'(hit2),  64'd0);
        checkOutput("clr_hist2", 64'(hist2), 64'd0);
        setPc(64'h4C);
        checkOutput("clr_nowrite_hit0", 64'(hit0), 64'd0);
        applyStimulus(1, 64'h4C, 1, 64'h400, 2'd0, 0, 0);
        applyStimulus(1, 64'h4C, 0, 64'h0, 2'd0, 0, 0);
        setPc(64'h4C);
        checkOutput("clr_pht_hit0",    64'(hit0),   64'd1);
        checkOutput("clr_pht_taken0",  64'(taken0), 64'd1);
        checkOutput("clr_pht_target0", target0,     64'h400);

        // Asynchronous reset in the middle of an update
        @(posedge clk);
        #2;
        upd_valid = 1'b1; upd_pc = 64'h4C; upd_taken = 1'b1; upd_target = 64'h400;
        upd_hist2 = 2'd0; upd_mispredict = 1'b1;
        #2 arst_n = 1'b0;
        #1;
        checkOutput("arst_hit0",    64'(hit0),    64'd0);
        checkOutput("arst_taken0",  64'(taken0),  64'd0);
        checkOutput("arst_target0", target0,      64'd0);
        checkOutput("arst_cnt0",    64'(cnt0),    64'd0);
        checkOutput("arst_hit2",    64'(hit2),    64'd0);
        checkOutput("arst_hist2",   64'(hist2),   64'd0);
        checkOutput("arst_cnt2",    64'(cnt2),    64'd0);
        @(posedge clk);
        #2;
        upd_valid = 1'b0; upd_mispredict = 1'b0; arst_n = 1'b1;
        applyStimulus(1, 64'h4C, 1, 64'h400, 2'd0, 0, 0);
        applyStimulus(1, 64'h4C, 0, 64'h0, 2'd0, 0, 0);
        setPc(64'h4C);
        checkOutput("post_rst_hit0",   64'(hit0),   64'd1);
        checkOutput("post_rst_taken0", 64'(taken0), 64'd0);

        repeat (2) @(posedge clk);
        #2;
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
